// File: rtl/ysyx_22050854_booth_mul_seq_if.sv
// Valid/ready request and result bundle between the EXU and the Booth multiplier.
// master = EXU side, slave = multiplier side.
interface ysyx_22050854_booth_mul_seq_if;
  logic        mul_valid;
  logic        mul_ready;
  logic        flush;
  logic        mulw;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand;
  logic [63:0] multiplier;
  logic        out_valid;
  logic [63:0] result_hi;
  logic [63:0] result_lo;

  modport master (
    output mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    input  mul_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  mul_valid, flush, mulw, mul_signed, multiplicand, multiplier,
    output mul_ready, out_valid, result_hi, result_lo
  );
endinterface

// File: rtl/ysyx_22050854_booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one partial product per cycle (33 iters, 17 for mulw).
// Define MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all equal.
module ysyx_22050854_booth_mul_seq (
  input  logic                              clk,
  input  logic                              rst_n,
  ysyx_22050854_booth_mul_seq_if.slave      mul_if
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e         state_q;
  logic [131:0]   a_q, a_d, a_init;
  logic [66:0]    b_q, b_d, b_init;
  logic [127:0]   acc_q, acc_d, pp;
  logic [5:0]     cnt_q;
  logic           mulw_q;
  logic [63:0]    res_hi_q, res_lo_q;
  logic           sa, sb, carry, last;
  logic           unused_a_top;

  assign mul_if.mul_ready = (state_q == IDLE);
  assign mul_if.out_valid = (state_q == DONE) & ~mul_if.flush;
  assign mul_if.result_hi = res_hi_q;
  assign mul_if.result_lo = res_lo_q;

  // Bits above 129 only carry sign fill and shift out without ever reaching the accumulator.
  assign unused_a_top = ^a_q[131:130];

  always_comb begin
    sa = mul_if.mul_signed[1] & (mul_if.mulw ? mul_if.multiplicand[31] : mul_if.multiplicand[63]);
    sb = mul_if.mul_signed[0] & (mul_if.mulw ? mul_if.multiplier[31]   : mul_if.multiplier[63]);
    a_init = mul_if.mulw ? {{100{sa}}, mul_if.multiplicand[31:0]}
                         : {{68{sa}},  mul_if.multiplicand};
    b_init = mul_if.mulw ? {{34{sb}}, mul_if.multiplier[31:0], 1'b0}
                         : {{2{sb}},  mul_if.multiplier, 1'b0};
  end

  always_comb begin
    pp    = '0;
    carry = 1'b0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q[127:0];
      3'b011:         pp = {a_q[126:0], 1'b0};
      3'b100: begin
        pp    = ~{a_q[126:0], 1'b0};
        carry = 1'b1;
      end
      3'b101, 3'b110: begin
        pp    = ~a_q[127:0];
        carry = 1'b1;
      end
      default:        pp = '0;
    endcase
    acc_d = acc_q + pp + {127'd0, carry};
    a_d   = {a_q[129:0], 2'b00};
    b_d   = {{2{b_q[66]}}, b_q[66:2]};
    last  = (cnt_q == (mulw_q ? 6'd16 : 6'd32));
`ifdef MUL_EARLY_EXIT_EN
    last  = last | (b_d == '0) | (b_d == '1);
`else
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      mulw_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul_if.mul_valid && !mul_if.flush) begin
            a_q     <= a_init;
            b_q     <= b_init;
            acc_q   <= '0;
            cnt_q   <= '0;
            mulw_q  <= mul_if.mulw;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (mul_if.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            a_q   <= a_d;
            b_q   <= b_d;
            cnt_q <= cnt_q + 6'd1;
            if (last) begin
              state_q <= DONE;
              if (mulw_q) begin
                res_hi_q <= '0;
                res_lo_q <= {{32{acc_d[31]}}, acc_d[31:0]};
              end else begin
                res_hi_q <= acc_d[127:64];
                res_lo_q <= acc_d[63:0];
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
